// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the memory-mapped UART transmitter.
//   - register offsets inside the 8-byte window
//   - bit positions of the STATUS register fields
//   - 2-bit encoding of the transmit state machine
package uart_pkg;

   // Register offsets (addr[2:0])
   localparam logic [2:0] UART_TXDATA = 3'd0;
   localparam logic [2:0] UART_STATUS = 3'd4;

   // STATUS register bit positions; the FIFO count field starts at ST_COUNT
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_COUNT = 4;

   // Transmit shifter states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: the core's shared data-port bus as seen by the UART.
//   ce      access enable
//   we      1 = write, 0 = read (qualified by ce)
//   addr    byte address
//   data_i  write data (core -> peripheral)
//   data_o  read data (peripheral -> core), combinational
// master: the core side, slave: the peripheral side.
interface uart_tx_mmio_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (
      output ce,
      output we,
      output addr,
      output data_i,
      input  data_o
   );

   modport slave (
      input  ce,
      input  we,
      input  addr,
      input  data_i,
      output data_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO for transmit bytes, read data taken straight
// from the storage array so the head entry is visible with no latency.
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push, din  enqueue din; ignored while full
//   pop, dout  dequeue; dout is the current head entry; ignored while empty
//   full, empty, count  occupancy flags and entry count (0..DEPTH)
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;

   logic push_ok;
   logic pop_ok;

   // Flags come from registered state only, so a pop at the same edge does
   // not make room for a push that arrives while full.
   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_reg[rd_ptr_reg];

   // Storage is not reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core's data port.
// Byte stores to TXDATA are queued in a small FIFO and shifted out LSB first;
// STATUS exposes full/empty/busy/ovf and the FIFO count.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        data-port bus (slave side): ce, we, addr, data_i, data_o
//   tx         serial line, registered, idles high
//   busy       high while the shifter is out of IDLE, registered
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_mmio_if.slave    bus,
   output logic             tx,
   output logic             busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);

   // ---------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------
   logic       hit;
   logic [2:0] offset;
   logic       wr_txdata;
   logic       wr_status;
   logic       rd_status;

   assign hit       = (bus.addr[31:3] == BASE_ADDR[31:3]);
   assign offset    = bus.addr[2:0];
   assign wr_txdata = bus.ce &&  bus.we && hit && (offset == UART_TXDATA);
   assign wr_status = bus.ce &&  bus.we && hit && (offset == UART_STATUS);
   assign rd_status = bus.ce && !bus.we && hit && (offset == UART_STATUS);

   // Only the low byte and the ovf-clear bit of write data matter.
   logic unused_data;
   assign unused_data = &{1'b0, bus.data_i[31:8]};

   // ---------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (bus.data_i[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------------------------------------------------------
   // Sticky overflow flag: set by a push into a full FIFO, cleared by a
   // STATUS write with bit 3 set. Both cannot happen in one cycle.
   // ---------------------------------------------------------------
   logic ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (wr_txdata && fifo_full) begin
         ovf_reg <= 1'b1;
      end else if (wr_status && bus.data_i[ST_OVF]) begin
         ovf_reg <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------
   tx_state_t     state_reg,  state_next;
   logic [BW-1:0] bcnt_reg,   bcnt_next;
   logic [2:0]    idx_reg,    idx_next;
   logic [7:0]    shift_reg,  shift_next;
   logic          tx_reg,     tx_next;
   logic          busy_reg,   busy_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         bcnt_reg  <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         bcnt_reg  <= bcnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
         busy_reg  <= busy_next;
      end
   end

   // tx and busy are computed for the state being entered so that both
   // outputs are registered and change exactly at the state transition.
   always_comb begin
      state_next = state_reg;
      bcnt_next  = bcnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      tx_next    = tx_reg;
      busy_next  = busy_reg;
      fifo_pop   = 1'b0;

      case (state_reg)
         S_IDLE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_dout;
               bcnt_next  = '0;
               state_next = S_START;
               tx_next    = 1'b0;
               busy_next  = 1'b1;
            end
         end
         S_START: begin
            if (bcnt_reg == BCNT_LAST) begin
               bcnt_next  = '0;
               idx_next   = '0;
               state_next = S_DATA;
               tx_next    = shift_reg[0];
            end else begin
               bcnt_next = bcnt_reg + BW'(1);
            end
         end
         S_DATA: begin
            if (bcnt_reg == BCNT_LAST) begin
               bcnt_next = '0;
               if (idx_reg == 3'd7) begin
                  state_next = S_STOP;
                  tx_next    = 1'b1;
               end else begin
                  idx_next = idx_reg + 3'd1;
                  tx_next  = shift_reg[idx_reg + 3'd1];
               end
            end else begin
               bcnt_next = bcnt_reg + BW'(1);
            end
         end
         S_STOP: begin
            if (bcnt_reg == BCNT_LAST) begin
               bcnt_next  = '0;
               state_next = S_IDLE;
               tx_next    = 1'b1;
               busy_next  = 1'b0;
            end else begin
               bcnt_next = bcnt_reg + BW'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign tx   = tx_reg;
   assign busy = busy_reg;

   // ---------------------------------------------------------------
   // Read mux: only STATUS returns data; everything else reads 0.
   // ---------------------------------------------------------------
   logic [31:0] status_word;
   logic [31:0] rd_data;

   always_comb begin
      status_word                 = '0;
      status_word[ST_FULL]        = fifo_full;
      status_word[ST_EMPTY]       = fifo_empty;
      status_word[ST_BUSY]        = busy_reg;
      status_word[ST_OVF]         = ovf_reg;
      status_word[ST_COUNT +: CW] = fifo_count;
   end

   always_comb begin
      rd_data = '0;
      if (rd_status) begin
         rd_data = status_word;
      end
   end

   assign bus.data_o = rd_data;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Outputs are sampled on the falling edge.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE     = 32'h1000_0000;
   localparam logic [31:0] TXDATA_A = BASE;
   localparam logic [31:0] STATUS_A = BASE + 32'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   logic busy;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .tx   (tx),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("RST  applied at %0t", $time);
   endtask

   // Drive at a falling edge, accepted at the following rising edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
      @(posedge clk);
      #1;
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
      $display("WR   addr=0x%08h data=0x%08h", a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1;
      d = bus.data_o;
      bus.ce = 1'b0; bus.addr = '0;
      $display("RD   addr=0x%08h data=0x%08h", a, d);
   endtask

   // Cycle-exact frame check. started=0: the start bit begins at the next
   // rising edge; started=1: it began at the most recent rising edge.
   // Ends after checking the idle cycle that follows the stop bit.
   task automatic check_frame(input string tag, input logic [7:0] b, input bit started);
      logic [9:0] bits;
      logic [7:0] dec;
      bits = {1'b1, b, 1'b0};
      dec  = '0;
      if (!started) @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check_eq({tag, "_tx"}, {31'b0, tx}, {31'b0, bits[k / 4]});
         check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
         if (k >= 6 && k <= 34 && (k % 4) == 2) dec[(k - 6) / 4] = tx;
      end
      check_eq({tag, "_byte"}, {24'b0, dec}, {24'b0, b});
      @(negedge clk);
      check_eq({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
      check_eq({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
      $display("FRM  %s byte=0x%02h", tag, dec);
   endtask

   // Waits for the current frame (if any) to end, then decodes the next one.
   task automatic capture_byte(output logic [7:0] b);
      int n;
      b = '0;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      check_eq("cap_wait_idle", {31'b0, (n < 200)}, 32'd1);
      n = 0;
      while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      check_eq("cap_wait_start", {31'b0, (n < 200)}, 32'd1);
      repeat (2) @(negedge clk);
      check_eq("cap_start_bit", {31'b0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = tx;
      end
      repeat (4) @(negedge clk);
      check_eq("cap_stop_bit", {31'b0, tx}, 32'd1);
      $display("CAP  byte=0x%02h", b);
   endtask

   // Counts low samples of tx over a window; a quiet line gives 0.
   task automatic count_low(input int cycles, output int lows);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  cb;
      logic [7:0]  exp_bytes [4];
      int          lows;

      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
      exp_bytes[0] = 8'hC3; exp_bytes[1] = 8'h5A;
      exp_bytes[2] = 8'h0F; exp_bytes[3] = 8'h96;

      // Reset state and STATUS after reset
      do_reset();
      @(negedge clk);
      check_eq("rst_tx", {31'b0, tx}, 32'd1);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      bus_read(STATUS_A, rd);
      check_eq("rst_status", rd, 32'h0000_0002);

      // Single frame 0x55, cycle exact; tx stays high at the write edge
      bus_write(TXDATA_A, 32'h0000_0055);
      check_eq("pre_start_tx", {31'b0, tx}, 32'd1);
      check_eq("pre_start_busy", {31'b0, busy}, 32'd0);
      check_frame("f55", 8'h55, 1'b0);

      // Back-to-back A5, 3C with exactly one idle cycle between them
      do_reset();
      bus_write(TXDATA_A, 32'h0000_00A5);
      bus_write(TXDATA_A, 32'h0000_003C);
      check_frame("fa5", 8'hA5, 1'b1);
      check_frame("f3c", 8'h3C, 1'b0);

      // STATUS with one queued byte while the shifter is busy
      do_reset();
      bus_write(TXDATA_A, 32'h0000_00A5);
      repeat (3) @(negedge clk);
      bus_write(TXDATA_A, 32'h0000_003C);
      bus_read(STATUS_A, rd);
      check_eq("status_busy_cnt1", rd, 32'h0000_0014);
      capture_byte(cb);
      check_eq("cap_3c", {24'b0, cb}, 32'h0000_003C);

      // Overflow: 5 writes during a frame, 4 accepted, ovf set then cleared
      do_reset();
      bus_write(TXDATA_A, 32'h0000_0011);
      for (int i = 0; i < 4; i++) bus_write(TXDATA_A, {24'b0, exp_bytes[i]});
      bus_write(TXDATA_A, 32'h0000_00E7);
      bus_read(STATUS_A, rd);
      check_eq("status_full_ovf", rd, 32'h0000_004D);
      bus_write(STATUS_A, 32'h0000_0008);
      bus_read(STATUS_A, rd);
      check_eq("status_ovf_clr", rd, 32'h0000_0045);
      for (int i = 0; i < 4; i++) begin
         capture_byte(cb);
         check_eq($sformatf("ovf_byte%0d", i), {24'b0, cb}, {24'b0, exp_bytes[i]});
      end
      count_low(80, lows);
      check_eq("ovf_no_extra", lows, 32'd0);
      bus_read(STATUS_A, rd);
      check_eq("ovf_status_drained", rd, 32'h0000_0002);

      // Reset mid-DATA with a byte still queued
      do_reset();
      bus_write(TXDATA_A, 32'h0000_0000);
      bus_write(TXDATA_A, 32'h0000_00AA);
      repeat (8) @(negedge clk);
      check_eq("mid_data_tx", {31'b0, tx}, 32'd0);
      do_reset();
      @(negedge clk);
      check_eq("midrst_tx", {31'b0, tx}, 32'd1);
      check_eq("midrst_busy", {31'b0, busy}, 32'd0);
      bus_read(STATUS_A, rd);
      check_eq("midrst_status", rd, 32'h0000_0002);
      count_low(60, lows);
      check_eq("midrst_quiet", lows, 32'd0);

      // Out-of-window and unused-offset accesses
      do_reset();
      bus_write(BASE + 32'd8, 32'h0000_0041);
      bus_write(32'h0000_0100, 32'h0000_0041);
      bus_read(BASE + 32'd8, rd);
      check_eq("miss_rd_base8", rd, 32'h0);
      bus_read(32'h0000_0100, rd);
      check_eq("miss_rd_100", rd, 32'h0);
      bus_read(BASE + 32'd2, rd);
      check_eq("unused_off_rd", rd, 32'h0);
      bus_read(STATUS_A, rd);
      check_eq("miss_status", rd, 32'h0000_0002);
      count_low(20, lows);
      check_eq("miss_quiet", lows, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data port, beside `data_mem`. It consumes the core's store traffic: byte stores to its address window are pushed into a small FIFO and shifted out serially as 8N1 frames. This gives bench and silicon a console output path. The SoC top routes the shared `ce`/`we`/`addr`/`data` bus to both `data_mem` and this block, and muxes this block's `data_o` into the core's read data when `addr` hits the window.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: word-aligned base of the 8-byte register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ce`  in  1  data bus access enable.
- `we`  in  1  1 = write, 0 = read; qualified by `ce`.
- `addr`  in  32  byte address.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data; combinational.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while the shifter is not in IDLE; registered.

## Operation
Address decode:
- Hit when `addr[31:3] == BASE_ADDR[31:3]`.
- No hit means no side effect, and `data_o` = 0.

Registers (offset = `addr[2:0]`; offsets other than 0 and 4 read 0 and ignore writes):
- **TXDATA, offset 0.**
  - Write: push `data_i[7:0]`.
  - Read: returns 0.
  - A push while the FIFO is full (sampled before the edge) is dropped and sets sticky `ovf`. This holds even if a pop happens at the same edge.
- **STATUS, offset 4.**
  - Read layout: bit0 `full`, bit1 `empty`, bit2 `busy`, bit3 `ovf`, bits[3+W:4] FIFO `count` with W = log2(`FIFO_DEPTH`)+1; upper bits 0.
  - Write with `data_i[3]`=1 clears `ovf`.
  - A clear and an overflowing push in the same cycle cannot occur, because they use different offsets.

Reads:
- `data_o` is valid combinationally when `ce && !we && hit`.
- Reads have no side effects.

FIFO:
- Push happens on a TXDATA write when the FIFO is not full.
- Pop happens when the FSM leaves IDLE.
- Pointers wrap modulo `FIFO_DEPTH`.
- `count` ranges 0..`FIFO_DEPTH`.

TX FSM (states IDLE, START, DATA, STOP; baud counter `bcnt` runs 0..`CLKS_PER_BIT`-1; bit index 0..7):
- **IDLE:** `tx`=1. If the FIFO is non-empty: pop into the shift register, set `bcnt`=0, go to START.
- **START:** `tx`=0. When `bcnt` reaches `CLKS_PER_BIT`-1, go to DATA with bit index 0.
- **DATA:** `tx` = `shift[idx]`, LSB first. Each bit is held `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then return to IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, FIFO empty (`count`=0), `ovf`=0, `bcnt`=0.
- Reset mid-frame: `tx` returns to 1 at the reset edge and the frame is truncated. FIFO contents are discarded.
- Write latency: a TXDATA write accepted at edge N updates `count` at N. At edge N+1 an idle FSM pops and `tx` goes low, so the start bit begins after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles of line time.
- Back-to-back frames have exactly one IDLE cycle (`tx`=1, `busy`=0) between them.
- `busy` rises at the same edge `tx` falls for the start bit. It falls at the edge ending STOP.
- STATUS reads reflect register state as of the last edge; there is no same-cycle bypass of a concurrent write.

## Structure
- Shared package `uart_pkg`: register offsets (`UART_TXDATA`=0, `UART_STATUS`=4), STATUS bit positions, and the 2-bit FSM state encoding.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO parameterised by depth and width 8. Its ports are `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It reads out directly from registers, with no read latency.
- The top holds the decode, STATUS mux, `ovf`, and FSM.
- Target size is about 200 lines total.

## Test plan
All tests use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. Reset, then write 8'h55 to TXDATA → `tx` low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. The frame is 40 cycles and `busy` is high exactly during it.
2. Write 8'hA5, 8'h3C back-to-back → two frames separated by exactly one idle-high cycle. Decoded bytes are A5 then 3C.
3. While the first frame is shifting, write 5 bytes → 4 accepted. STATUS reads `full`=1 and `ovf`=1. Write STATUS with 32'h8 → `ovf`=0. The dropped byte is never transmitted.
4. Read STATUS after reset → 32'h0000_0002. After one write with the FSM already busy → `count`=1 and `busy`=1.
5. Assert `rst` for one cycle mid-DATA → next cycle `tx`=1, `busy`=0, STATUS = 32'h2. Nothing else is transmitted.
6. Write to `BASE_ADDR`+8 and to 32'h0000_0100 → no push, and `data_o`=0 for reads of both addresses.
